// File: rtl/adc_hamming_seq_if.sv
// Datapath launch/return bus and result handshake of the ADC Hamming sequencer.
// Handshake: a result transfers on any clock edge where out_valid && out_ready; once raised,
// out_valid and its payload (out_data/out_err/out_syn) hold steady until that edge.
interface adc_hamming_seq_if;
    logic [7:0] dp_vin;
    logic       dp_parity;
    logic       dp_start;
    logic [7:1] dp_code;
    logic [3:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       out_err;
    logic [2:0] out_syn;

    modport master (
        output dp_vin, dp_parity, dp_start, out_data, out_valid, out_err, out_syn,
        input  dp_code, out_ready
    );

    modport slave (
        input  dp_vin, dp_parity, dp_start, out_data, out_valid, out_err, out_syn,
        output dp_code, out_ready
    );
endinterface

// File: rtl/adc_hamming_seq.sv
// Sample scheduler for the flash-ADC + Hamming(7,4) datapath: launches a sample on each tick,
// captures the codeword DP_LAT cycles later, corrects it by syndrome and delivers the nibble.
module adc_hamming_seq #(
    parameter int SAMPLE_DIV = 16,
    parameter int DP_LAT     = 2,
    parameter int CNT_W      = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [7:0]        vin,
    input  logic              parity_type,
    adc_hamming_seq_if.master bus,
    output logic [CNT_W-1:0]  err_cnt,
    output logic [CNT_W-1:0]  ovr_cnt,
    output logic [1:0]        dbg_state
);
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_CHECK = 2'd2, S_HOLD = 2'd3} state_t;

    localparam logic [15:0] TICK_LAST = 16'(SAMPLE_DIV - 1);
    localparam logic [3:0]  WAIT_INIT = 4'(DP_LAT);

    state_t           r_state, w_next;
    logic [15:0]      r_tick_cnt;
    logic [3:0]       r_wait;
    logic [7:0]       r_dp_vin;
    logic             r_dp_parity, r_dp_start;
    logic [7:1]       r_code;
    logic [3:0]       r_out_data;
    logic             r_out_valid, r_out_err;
    logic [2:0]       r_out_syn;
    logic [CNT_W-1:0] r_err_cnt, r_ovr_cnt;
    logic             w_tick, w_launch, w_capture, w_check, w_hs, w_drop;
    logic [2:0]       w_syn;
    logic [3:0]       w_data;

    assign w_tick = enable && (r_tick_cnt == TICK_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)          r_tick_cnt <= '0;
        else if (!enable) r_tick_cnt <= '0;
        else if (w_tick)  r_tick_cnt <= '0;
        else              r_tick_cnt <= r_tick_cnt + 16'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_tick) w_next = S_WAIT;
            S_WAIT:  if (r_wait == 4'd1) w_next = S_CHECK;
            S_CHECK: w_next = S_HOLD;
            S_HOLD:  if (r_out_valid && bus.out_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // A tick is only honoured in IDLE; the handshake cycle of HOLD still drops it.
    always_comb begin
        w_launch  = 1'b0;
        w_capture = 1'b0;
        w_check   = 1'b0;
        w_hs      = 1'b0;
        w_drop    = w_tick && (r_state != S_IDLE);
        case (r_state)
            S_IDLE:  w_launch  = w_tick;
            S_WAIT:  w_capture = (r_wait == 4'd1);
            S_CHECK: w_check   = 1'b1;
            S_HOLD:  w_hs      = r_out_valid && bus.out_ready;
            default: ;
        endcase
    end

    assign w_syn[0] = r_code[1] ^ r_code[3] ^ r_code[5] ^ r_code[7] ^ r_dp_parity;
    assign w_syn[1] = r_code[2] ^ r_code[3] ^ r_code[6] ^ r_code[7] ^ r_dp_parity;
    assign w_syn[2] = r_code[4] ^ r_code[5] ^ r_code[6] ^ r_code[7] ^ r_dp_parity;
    assign w_data   = {r_code[7] ^ (w_syn == 3'd7), r_code[6] ^ (w_syn == 3'd6),
                       r_code[5] ^ (w_syn == 3'd5), r_code[3] ^ (w_syn == 3'd3)};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wait      <= '0;
            r_dp_vin    <= '0;
            r_dp_parity <= 1'b0;
            r_dp_start  <= 1'b0;
            r_code      <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_err   <= 1'b0;
            r_out_syn   <= '0;
            r_err_cnt   <= '0;
            r_ovr_cnt   <= '0;
        end else begin
            r_dp_start <= w_launch;
            if (w_launch) begin
                r_dp_vin    <= vin;
                r_dp_parity <= parity_type;
                r_wait      <= WAIT_INIT;
            end else if (r_state == S_WAIT && r_wait != 4'd1) begin
                r_wait <= r_wait - 4'd1;
            end
            if (w_capture) r_code <= bus.dp_code;
            if (w_check) begin
                r_out_data  <= w_data;
                r_out_err   <= (w_syn != 3'd0);
                r_out_syn   <= w_syn;
                r_out_valid <= 1'b1;
            end else if (w_hs) begin
                r_out_valid <= 1'b0;
            end
            if (w_hs && r_out_err && r_err_cnt != '1) r_err_cnt <= r_err_cnt + CNT_W'(1);
            if (w_drop && r_ovr_cnt != '1)           r_ovr_cnt <= r_ovr_cnt + CNT_W'(1);
        end
    end

    assign bus.dp_vin    = r_dp_vin;
    assign bus.dp_parity = r_dp_parity;
    assign bus.dp_start  = r_dp_start;
    assign bus.out_data  = r_out_data;
    assign bus.out_valid = r_out_valid;
    assign bus.out_err   = r_out_err;
    assign bus.out_syn   = r_out_syn;
    assign err_cnt       = r_err_cnt;
    assign ovr_cnt       = r_ovr_cnt;
    assign dbg_state     = r_state;
endmodule

// File: tb/tb_adc_hamming_seq.sv
// Bench for adc_hamming_seq: acts as the ADC/encoder datapath, drives random samples and
// backpressure, and scores results, counters and launch timing against a reference model.
module tb_adc_hamming_seq;
    localparam int SD = 6;
    localparam int DL = 2;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          rst, enable, parity_type;
    logic [7:0]    vin;
    logic [CW-1:0] err_cnt, ovr_cnt;
    logic [1:0]    dbg_state;

    adc_hamming_seq_if bus ();

    adc_hamming_seq #(.SAMPLE_DIV(SD), .DP_LAT(DL), .CNT_W(CW)) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .vin         (vin),
        .parity_type (parity_type),
        .bus         (bus),
        .err_cnt     (err_cnt),
        .ovr_cnt     (ovr_cnt),
        .dbg_state   (dbg_state)
    );

    always #5 clk = ~clk;

    // Scoreboard entries: {forced, data[3:0], err, syn[2:0]}
    logic [8:0]    exp_q[$];
    int            n_chk = 0, n_pass = 0, cyc = 0, run = 0, cd = -1, launch_cyc = 0, n_forced = 0;
    logic          busy = 1'b0, pend = 1'b0, prev_valid = 1'b0, prev_hs = 1'b0, mon_hs;
    logic [7:0]    prev_res = '0, prev_vin = '0, exp_vin = '0;
    logic          prev_par = 1'b0, exp_par = 1'b0;
    logic [CW-1:0] exp_err = '0, exp_ovr = '0;
    logic [6:0]    cur_code = '0;
    logic [8:0]    mon_e;
    logic          force_on = 1'b0;
    logic [6:0]    force_code = '0;
    logic [7:0]    force_exp = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Syndrome = XOR of the positions of all set bits, complemented per group in odd mode.
    function automatic logic [7:0] ref_result(input logic [6:0] code, input logic p);
        int         syn;
        logic [7:0] word;
        syn  = 0;
        word = {code, 1'b0};
        for (int i = 1; i <= 7; i++) if (word[i]) syn = syn ^ i;
        if (p) syn = syn ^ 7;
        if (syn != 0) word[syn] = ~word[syn];
        return {word[7], word[6], word[5], word[3], (syn != 0), 3'(syn)};
    endfunction

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            chk("reset_outputs", {bus.dp_vin, bus.dp_parity, bus.dp_start, bus.out_data,
                bus.out_valid, bus.out_err, bus.out_syn, err_cnt, ovr_cnt}, 32'd0);
            exp_q.delete();
            busy = 1'b0; pend = 1'b0; run = 0; cd = -1;
            exp_err = '0; exp_ovr = '0; exp_vin = '0; exp_par = 1'b0;
            prev_valid = 1'b0; prev_hs = 1'b0;
        end else begin
            chk("err_cnt", err_cnt, exp_err);
            chk("ovr_cnt", ovr_cnt, exp_ovr);
            chk("dp_start", bus.dp_start, pend);
            bus.dp_code = ~cur_code;
            if (pend) begin
                pend       = 1'b0;
                exp_vin    = prev_vin;
                exp_par    = prev_par;
                launch_cyc = cyc;
                if (force_on) begin
                    cur_code = force_code;
                    exp_q.push_back({1'b1, force_exp});
                end else begin
                    cur_code = 7'($urandom);
                    exp_q.push_back({1'b0, ref_result(cur_code, exp_par)});
                end
                cd = DL - 1;
            end else if (cd > 0) begin
                cd--;
            end
            if (cd == 0) begin
                bus.dp_code = cur_code;
                cd = -1;
            end
            chk("dp_vin", bus.dp_vin, exp_vin);
            chk("dp_parity", bus.dp_parity, exp_par);
            if (bus.out_valid && !prev_valid) chk("latency", cyc - launch_cyc, DL + 1);
            if (prev_valid && !prev_hs)
                chk("hold_stable", {bus.out_valid, bus.out_data, bus.out_err, bus.out_syn},
                    {1'b1, prev_res});
            mon_hs = bus.out_valid && bus.out_ready;
            if (mon_hs) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_result", bus.out_valid, 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("result", {bus.out_data, bus.out_err, bus.out_syn}, mon_e[7:0]);
                    if (mon_e[3] && exp_err != '1) exp_err = exp_err + 1'b1;
                    if (mon_e[8]) n_forced++;
                end
            end
            // Ticks fall on every SD-th consecutive enabled cycle.
            run = enable ? run + 1 : 0;
            if (enable && (run % SD) == 0) begin
                if (busy) begin
                    if (exp_ovr != '1) exp_ovr = exp_ovr + 1'b1;
                end else begin
                    pend = 1'b1;
                    busy = 1'b1;
                end
            end
            if (mon_hs) busy = 1'b0;
            prev_valid = bus.out_valid;
            prev_hs    = mon_hs;
            prev_res   = {bus.out_data, bus.out_err, bus.out_syn};
        end
        prev_vin = vin;
        prev_par = parity_type;
    end

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1 vin = 8'($urandom);
        end
    endtask

    task automatic wait_launch();
        int k;
        for (k = 0; k < 4 * SD; k++) begin
            step(1);
            if (bus.dp_start) break;
        end
        if (k == 4 * SD) chk("launch_timeout", bus.dp_start, 32'd1);
    endtask

    task automatic directed(input logic [6:0] code, input logic par, input logic [7:0] exp);
        int start;
        int k;
        start       = n_forced;
        parity_type = par;
        force_code  = code;
        force_exp   = exp;
        force_on    = 1'b1;
        for (k = 0; k < 8 * SD && n_forced == start; k++) step(1);
        force_on = 1'b0;
        if (n_forced == start) chk("directed_timeout", n_forced, start + 1);
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; vin = '0; parity_type = 1'b0;
        bus.out_ready = 1'b0; bus.dp_code = '0;
        step(3);
        rst = 1'b0;
        step(2);
        enable = 1'b1; bus.out_ready = 1'b1;

        // Reset in the middle of WAIT, then restart from a freshly enabled counter.
        wait_launch();
        step(1);
        rst = 1'b1;
        #1 chk("async_reset", {bus.dp_vin, bus.dp_parity, bus.dp_start, bus.out_valid,
                               err_cnt, ovr_cnt}, 32'd0);
        step(2);
        rst = 1'b0;

        directed(7'b1010101, 1'b0, {4'b1011, 1'b0, 3'd0});
        chk("err_cnt_clean", err_cnt, 32'd0);
        directed(7'b1000101, 1'b0, {4'b1011, 1'b1, 3'd5});
        chk("err_cnt_single", err_cnt, 32'd1);
        directed(7'b1011110, 1'b1, {4'b1011, 1'b0, 3'd0});
        directed(7'b1011110, 1'b0, {4'b0011, 1'b1, 3'd7});
        chk("err_cnt_directed", err_cnt, 32'd2);

        // Stall the consumer across three ticks right after a launch.
        wait_launch();
        bus.out_ready = 1'b0;
        step(3 * SD);
        chk("ovr_backpressure", ovr_cnt, 32'd3);
        bus.out_ready = 1'b1;
        step(2 * SD);

        // Drop enable while a sample is in flight.
        wait_launch();
        enable = 1'b0;
        step(3 * SD);
        chk("enable_off_drained", busy, 32'd0);
        enable = 1'b1;

        for (int i = 0; i < 700; i++) begin
            parity_type   = 1'($urandom_range(0, 1));
            bus.out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 99) < 2)                       enable = 1'b0;
            else if (!enable && $urandom_range(0, 3) == 0)       enable = 1'b1;
            step(1);
        end

        enable = 1'b0; bus.out_ready = 1'b1;
        step(6 * SD);
        chk("queue_drained", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish (%0d/%0d checks passed)", n_pass, n_chk);
        $fatal(1);
    end
endmodule

// File: doc/adc_hamming_seq.md
Name: adc_hamming_seq

Overview:
- Sample scheduler and checker for the flash-ADC + Hamming(7,4) datapath.
- Periodically latches the scaled analog input and parity mode, and presents them to the combinational ADC/encoder path.
- Waits a fixed settle latency, then captures the 7-bit codeword and checks/corrects it by syndrome.
- Delivers 4-bit data over a valid/ready handshake, with error and overrun statistics.

Parameters:
- SAMPLE_DIV, 16: clock cycles between sample ticks; legal range 4..65535.
- DP_LAT, 2: cycles from dp_start until dp_code is stable; legal range 1..15.
- CNT_W, 8: width of the statistic counters.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  run sampling; 0 freezes the tick counter at 0.
- vin  in  8  scaled analog input (for example, 25 = 2.5 V).
- parity_type  in  1  0 = even parity, 1 = odd parity.
- dp_vin  out  8  registered Vin presented to the datapath.
- dp_parity  out  1  registered parity mode presented to the datapath.
- dp_start  out  1  one-cycle pulse when a new sample is launched.
- dp_code  in  [7:1]  codeword returned by the datapath; bit i = Hamming position i.
- out_data  out  4  corrected data {c7,c6,c5,c3}.
- out_valid  out  1  out_data, out_err and out_syn are valid.
- out_ready  in  1  consumer accepts the result.
- out_err  out  1  nonzero syndrome was found (single-bit error corrected).
- out_syn  out  3  syndrome {s4,s2,s1}.
- err_cnt  out  CNT_W  saturating count of delivered results with out_err = 1.
- ovr_cnt  out  CNT_W  saturating count of dropped ticks.

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is asynchronous and active-high.
- Reset values: every output and register is 0, including dp_vin, dp_parity, dp_start, out_*, both counters and the tick counter. FSM state is IDLE.
- Tick counter:
  - Increments while enable = 1 and wraps at SAMPLE_DIV-1.
  - tick is asserted in the cycle the counter equals SAMPLE_DIV-1.
  - enable = 0 clears the counter synchronously.
- FSM states: IDLE, WAIT, CHECK, HOLD.
- IDLE:
  - On tick, latch vin -> dp_vin and parity_type -> dp_parity.
  - Pulse dp_start for 1 cycle, load the wait counter with DP_LAT, go to WAIT.
- WAIT:
  - Decrement the wait counter.
  - When it reaches 1, capture dp_code and go to CHECK.
  - Capture therefore occurs DP_LAT cycles after the dp_start cycle.
- CHECK (1 cycle):
  - s1 = c1^c3^c5^c7^p
  - s2 = c2^c3^c6^c7^p
  - s4 = c4^c5^c6^c7^p
  - p is the latched dp_parity.
  - syn = {s4,s2,s1}. If syn != 0, invert codeword bit[syn].
  - Register out_data = {c7,c6,c5,c3} of the corrected word, out_err = (syn != 0), and out_syn.
  - Go to HOLD with out_valid = 1.
- HOLD:
  - out_valid, out_data, out_err and out_syn stay stable until out_valid & out_ready.
  - In the handshake cycle: clear out_valid, increment err_cnt if out_err, return to IDLE.
  - Results are delivered only via handshake; no result is ever overwritten.
- Latency: dp_start to out_valid = DP_LAT+1 cycles when out_ready is held high.
- Overrun:
  - A tick in any state other than IDLE is dropped and increments ovr_cnt.
  - The tick counter keeps running.
  - A tick in the same cycle as the HOLD handshake is also dropped, because the FSM is not yet in IDLE.
- Counters saturate at 2^CNT_W-1 and never wrap.
- enable = 0 mid-operation: the in-flight sample completes and is delivered normally. No new ticks are generated.
- rst mid-operation: immediate abort. Every output returns to 0 asynchronously, and the pending result is lost.
- dp_vin and dp_parity stay constant from launch until the next launch.

Test Plan:
- Reset: assert rst mid-WAIT -> all outputs 0 immediately; after release, the first dp_start occurs exactly SAMPLE_DIV cycles after the first enabled edge.
- Clean even: parity_type = 0, datapath model returns 7'b1010101, out_ready = 1 -> out_valid 3 cycles after dp_start (DP_LAT = 2), out_data = 4'b1011, out_err = 0, out_syn = 0, err_cnt unchanged.
- Single-bit error: even mode, dp_code = 7'b1000101 (bit 5 flipped) -> out_syn = 3'd5, out_err = 1, out_data = 4'b1011, err_cnt +1 after the handshake.
- Odd parity: parity_type = 1, dp_code = 7'b1011110 -> out_syn = 0, out_data = 4'b1011; the same word in even mode -> out_syn = 3'b111, out_data = 4'b0011 (bit 7 inverted).
- Backpressure/overrun: out_ready = 0 for 3·SAMPLE_DIV cycles -> out_data stable, ovr_cnt = 3, no dp_start pulses; after out_ready = 1 the next launch occurs on the following tick.
- Saturation: CNT_W = 2, force 5 errored results -> err_cnt stays at 3.
